alu_op_dispatch: RTL

//  Front end of the 8-bit ALU: accepts one operation request (opcode, operands) per handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_op_dispatch_seq_multiplier.sv | 70 +++++++
 rtl/alu_op_dispatch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings plus default widths for the 8-bit ALU front end.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int RES_W_DEF  = 2 * DATA_W_DEF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_MUL = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_dispatch_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, DATA_W iterations after start.
// done/product are combinational on the final iteration so the caller can register the result that edge.
module seq_multiplier #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [RES_W-1:0]  sum;

  always_comb begin
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = RES_W'(a);
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST);
  assign product = sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // datapath registers carry no reset; busy_q gates their meaning
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/alu_op_dispatch.sv
// ALU front end: accepts one op per handshake, routes to add/and/xor or the sequential multiplier,
// returns a held 16-bit result. Define ALU_FLAGS_EN to add the zero/neg/carry result flags.
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data
`ifdef ALU_FLAGS_EN
  ,
  output logic              res_zero,
  output logic              res_neg,
  output logic              res_carry
`endif
);

  function automatic logic [RES_W-1:0] sext(input logic [DATA_W-1:0] r);
    return {{(RES_W - DATA_W){r[DATA_W-1]}}, r};
  endfunction

  function automatic logic [DATA_W-1:0] alu_simple(input opcode_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               mul_start, mul_busy, mul_done;
  logic [RES_W-1:0]   mul_product;
  opcode_e            op_in;

  assign op_in     = opcode_e'(req_opcode);
  assign req_ready = (state_q == S_IDLE) && !mul_busy;
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_data_q;

  seq_multiplier #(
    .DATA_W(DATA_W),
    .RES_W (RES_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (req_a),
    .b      (req_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    mul_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (op_in == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            res_data_d = sext(alu_simple(op_in, req_a, req_b));
            state_d    = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          res_data_d = mul_product;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;

  function automatic logic add_carry(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return 1'(({1'b0, a} + {1'b0, b}) >> DATA_W);
  endfunction

  // flags load on the same edge the result register enters DONE
  always_comb begin
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      zero_d  = (res_data_d == '0);
      neg_d   = res_data_d[RES_W-1];
      carry_d = (state_q == S_IDLE && op_in == OP_ADD) ? add_carry(req_a, req_b) : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
    end
  end

  assign res_zero  = zero_q;
  assign res_neg   = neg_q;
  assign res_carry = carry_q;
`endif

endmodule
